ama_riscv_imm_enc: RTL and testbench
====================================

# ama_riscv_imm_enc

Immediate encoder: the inverse of immediate generation. Takes a 32-bit immediate, an immediate-type select and a 32-bit instruction template, and scatters the immediate into the template's instruction fields for the selected format. It also flags immediates the format cannot represent. Pipelined with valid/ready handshakes; it sits in the instruction-patching path (boot-ROM relocation, branch/jump fix-up) ahead of instruction memory writes.

## Interface
- `CNT_W`, 16, width of the saturating error counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_sel`  in  4  immediate type; values are the shared `IG_I_TYPE`, `IG_S_TYPE`, `IG_B_TYPE`, `IG_J_TYPE` and `IG_U_TYPE` constants.
- `in_imm`  in  32  immediate value (two's complement; U-type is the full upper value).
- `in_inst`  in  32  instruction template; non-immediate bits pass through.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_inst`  out  32  encoded instruction.
- `out_err`  out  1  immediate not representable, or `in_sel` invalid.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `err_cnt`  out  CNT_W  saturating count of errored beats delivered.

## Operation
- Field mapping; all bits not listed come from `in_inst`:
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - U: inst[31:12]=imm[31:12].
- Range check; err=1 when violated:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
- On error the fields are still written with the truncated bits listed above, so the output is deterministic.
- Any other `in_sel` value: `out_inst`=`in_inst` unchanged, err=1.
- Error counter:
  - Increments on `out_valid && out_ready && out_err` and saturates at all-ones.
  - `clr_cnt` wins over an increment in the same cycle; the counter reads 0 the next cycle.

## Timing
- Two register stages, S1 and S2:
  - S1 captures `in_sel`/`in_imm`/`in_inst`.
  - S2 holds the encoded `out_inst`/`out_err`; encode and check logic sits between S1 and S2.
- `out_valid`=S2 valid.
- S2 loads when it is empty or `out_ready`=1.
- S1 advances when S2 loads.
- `in_ready` = !S1_valid || S2 loads. This is a combinational path from `out_ready`.
- Latency: a beat accepted at edge k appears on `out_valid` after edge k+1 (2 edges). Throughput is 1 beat/cycle.
- Under backpressure, S2 and its outputs hold stable while `out_valid && !out_ready`. With a stalled output the block holds at most 2 beats, then `in_ready`=0.
- Accepts and delivers in the same cycle are supported; beat order is preserved.
- Reset values: S1/S2 valid=0, `out_valid`=0, `out_inst`=0, `out_err`=0, `err_cnt`=0.
- Reset asserted mid-operation discards in-flight beats immediately. `in_ready`=1 after release.

## Structure
- `IG_*` select codes live in the shared defines file, unchanged, so encoder and generator use one encoding.
- Format bit positions stay local to this block.
- One combinational sub-module, `ama_riscv_imm_enc_chk`: (sel, imm) → err. It is reused by the generator's assertion checks.
- Top-level module holds the two pipeline stages and the counter.

## Test plan
- I-type, template 0x00000013, imm 0xFFFFFFFF → `out_inst`=0xFFF00013, err=0, out 2 edges after accept.
- B-type, template 0x00000063, imm 0x00000800 → 0x000000E3, err=0.
- J-type, template 0x0000006F, imm 0x00000800 → 0x0010006F, err=0. U-type, template 0x00000037, imm 0x12345000 → 0x12345037, err=0.
- Errors:
  - B imm 0x00001001 → err=1.
  - S imm 0x00000800 → err=1.
  - `in_sel`=invalid, template 0xDEADBEEF → 0xDEADBEEF, err=1.
  - Result: `err_cnt`=3.
  - `clr_cnt` pulsed together with a 4th error delivery → `err_cnt`=0.
- Backpressure:
  - 4 back-to-back beats, `out_ready`=0 for 5 cycles → 2 accepted, `in_ready`=0, outputs stable.
  - `out_ready`=1 → all 4 delivered in order, one per cycle.
- Reset asserted with 2 beats in flight → `out_valid`=0 asynchronously, no stale beat after release, `err_cnt`=0.

Source files
------------

// File: rtl/ama_riscv_imm_enc_pkg.sv
// Shared immediate-type select codes and the format-specific field scatter
// used by the immediate encoder pipeline.
package ama_riscv_imm_enc_pkg;

  localparam logic [3:0] IG_DISABLED = 4'd0;
  localparam logic [3:0] IG_I_TYPE   = 4'd1;
  localparam logic [3:0] IG_S_TYPE   = 4'd2;
  localparam logic [3:0] IG_B_TYPE   = 4'd3;
  localparam logic [3:0] IG_J_TYPE   = 4'd4;
  localparam logic [3:0] IG_U_TYPE   = 4'd5;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] imm;
    logic [31:0] inst;
  } imm_enc_beat_t;

  // Scatter the immediate into the template; unknown selects leave it intact.
  function automatic logic [31:0] imm_encode(
    input logic [3:0]  sel,
    input logic [31:0] imm,
    input logic [31:0] inst
  );
    logic [31:0] r;
    r = inst;
    case (sel)
      IG_I_TYPE: begin
        r[31:20] = imm[11:0];
      end
      IG_S_TYPE: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      IG_B_TYPE: begin
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
      end
      IG_J_TYPE: begin
        r[31]    = imm[20];
        r[30:21] = imm[10:1];
        r[20]    = imm[11];
        r[19:12] = imm[19:12];
      end
      IG_U_TYPE: begin
        r[31:12] = imm[31:12];
      end
      default: begin
        r = inst;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ama_riscv_imm_enc_chk.sv
// Range check: flags immediates the selected format cannot represent,
// and any select value that is not a known format.
module ama_riscv_imm_enc_chk
  import ama_riscv_imm_enc_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] imm,
  output logic        err
);

  logic ext_11_ok;
  logic ext_12_ok;
  logic ext_20_ok;

  // Upper bits must all be sign copies of the top encodable bit.
  assign ext_11_ok = (&imm[31:11]) || !(|imm[31:11]);
  assign ext_12_ok = (&imm[31:12]) || !(|imm[31:12]);
  assign ext_20_ok = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    err = 1'b1;
    case (sel)
      IG_I_TYPE, IG_S_TYPE: err = !ext_11_ok;
      IG_B_TYPE:            err = !ext_12_ok || imm[0];
      IG_J_TYPE:            err = !ext_20_ok || imm[0];
      IG_U_TYPE:            err = |imm[11:0];
      default:              err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ama_riscv_imm_enc.sv
// Two-stage valid/ready immediate encoder: S1 captures the request, S2 holds
// the encoded instruction and error flag; errored deliveries are counted.
module ama_riscv_imm_enc
  import ama_riscv_imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  imm_enc_beat_t    s1_reg;
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic [31:0]      s2_inst_reg;
  logic             s2_err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             s2_load;
  logic [31:0]      enc_inst;
  logic             chk_err;

  // S2 frees up when empty or being drained; S1 moves whenever S2 loads.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_load;

  assign enc_inst = imm_encode(s1_reg.sel, s1_reg.imm, s1_reg.inst);

  ama_riscv_imm_enc_chk u_chk (
    .sel (s1_reg.sel),
    .imm (s1_reg.imm),
    .err (chk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_reg <= '{sel: in_sel, imm: in_imm, inst: in_inst};
      end
    end
  end

  // Data only updates on a real beat so an idle S2 keeps its last contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_inst_reg  <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_inst_reg <= enc_inst;
        s2_err_reg  <= chk_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr_cnt) begin
      cnt_reg <= '0;
    end else if (s2_valid_reg && out_ready && s2_err_reg &&
                 (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_inst  = s2_inst_reg;
  assign out_err   = s2_err_reg;
  assign err_cnt   = cnt_reg;

endmodule

// File: tb/tb_ama_riscv_imm_enc.sv
// Directed bench for the immediate encoder: encodings, range errors,
// error counter, backpressure and asynchronous reset.
module tb_ama_riscv_imm_enc;
  import ama_riscv_imm_enc_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_sel = '0;
  logic [31:0]      in_imm = '0;
  logic [31:0]      in_inst = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_inst;
  logic             out_err;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  ama_riscv_imm_enc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Present one beat, wait (bounded) for acceptance; returns on the
  // falling edge right after the accepting rising edge.
  task automatic drive_one(input logic [3:0] sel, input logic [31:0] imm,
                           input logic [31:0] inst);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = sel;
    in_imm   = imm;
    in_inst  = inst;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%0b inst=%08h err=%0b cnt=%0d required 0/0/0/0",
               out_valid, out_inst, out_err, err_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready in_ready=%0b required 1", in_ready);
    end
    $display("reset: valid=%0b inst=%08h cnt=%0d", out_valid, out_inst, err_cnt);
  endtask

  task automatic test_encode;
    logic [3:0]  sel_t [4];
    logic [31:0] imm_t [4];
    logic [31:0] tpl_t [4];
    logic [31:0] exp_t [4];
    sel_t = '{IG_I_TYPE, IG_B_TYPE, IG_J_TYPE, IG_U_TYPE};
    imm_t = '{32'hFFFF_FFFF, 32'h0000_0800, 32'h0000_0800, 32'h1234_5000};
    tpl_t = '{32'h0000_0013, 32'h0000_0063, 32'h0000_006F, 32'h0000_0037};
    exp_t = '{32'hFFF0_0013, 32'h0000_00E3, 32'h0010_006F, 32'h1234_5037};
    for (int i = 0; i < 4; i++) begin
      drive_one(sel_t[i], imm_t[i], tpl_t[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL encode_latency_early[%0d] out_valid=%0b required 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_inst !== exp_t[i] || out_err !== 1'b0) begin
        errors++;
        $display("FAIL encode[%0d] valid=%0b inst=%08h err=%0b required 1/%08h/0",
                 i, out_valid, out_inst, out_err, exp_t[i]);
      end
      $display("encode[%0d]: sel=%0d imm=%08h inst=%08h err=%0b", i, sel_t[i], imm_t[i],
               out_inst, out_err);
    end
  endtask

  task automatic test_errors;
    logic [3:0]  sel_t [3];
    logic [31:0] imm_t [3];
    logic [31:0] tpl_t [3];
    logic [31:0] exp_t [3];
    sel_t = '{IG_B_TYPE, IG_S_TYPE, 4'hF};
    imm_t = '{32'h0000_1001, 32'h0000_0800, 32'h0000_0000};
    tpl_t = '{32'h0000_0063, 32'h0000_0023, 32'hDEAD_BEEF};
    exp_t = '{32'h8000_0063, 32'h8000_0023, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      drive_one(sel_t[i], imm_t[i], tpl_t[i]);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_inst !== exp_t[i] || out_err !== 1'b1) begin
        errors++;
        $display("FAIL error_beat[%0d] valid=%0b inst=%08h err=%0b required 1/%08h/1",
                 i, out_valid, out_inst, out_err, exp_t[i]);
      end
      $display("error[%0d]: sel=%0d imm=%08h inst=%08h err=%0b", i, sel_t[i], imm_t[i],
               out_inst, out_err);
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_cnt_after_3 err_cnt=%0d required 3", err_cnt);
    end
  endtask

  task automatic test_clr_cnt;
    drive_one(IG_B_TYPE, 32'h0000_1001, 32'h0000_0063);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL clr_pre valid=%0b err=%0b cnt=%0d required 1/1/3",
               out_valid, out_err, err_cnt);
    end
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 16'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins cnt=%0d valid=%0b required 0/0", err_cnt, out_valid);
    end
    $display("clr: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [4];
    logic [31:0] held;
    bit          have_held;
    bit          acc;
    int          sent;
    int          got;
    exp_q = '{32'h0010_0013, 32'h0020_0013, 32'h0030_0013, 32'h0040_0013};
    sent = 0;
    got = 0;
    have_held = 1'b0;
    held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (sent < 4);
      in_sel   = IG_I_TYPE;
      in_imm   = sent + 1;
      in_inst  = 32'h0000_0013;
      #1;
      if (have_held) begin
        checks++;
        if (out_valid !== 1'b1 || out_inst !== held) begin
          errors++;
          $display("FAIL stall_stable valid=%0b inst=%08h required 1/%08h",
                   out_valid, out_inst, held);
        end
      end else if (out_valid) begin
        held = out_inst;
        have_held = 1'b1;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sent !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== exp_q[0]) begin
      errors++;
      $display("FAIL stall_fill sent=%0d in_ready=%0b valid=%0b inst=%08h required 2/0/1/%08h",
               sent, in_ready, out_valid, out_inst, exp_q[0]);
    end
    $display("stall: accepted=%0d in_ready=%0b inst=%08h", sent, in_ready, out_inst);
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 4);
      in_imm    = sent + 1;
      #1;
      if (out_valid) begin
        checks++;
        if (out_inst !== exp_q[got] || out_err !== 1'b0) begin
          errors++;
          $display("FAIL drain_order[%0d] inst=%08h err=%0b required %08h/0",
                   got, out_inst, out_err, exp_q[got]);
        end
        $display("drain[%0d]: inst=%08h", got, out_inst);
        got++;
      end else if (got > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_gap out_valid=%0b required 1 after %0d beats", out_valid, got);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL drain_count got=%0d required 4", got);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    drive_one(IG_S_TYPE, 32'h0000_0800, 32'h0000_0023);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_cnt err_cnt=%0d required 1", err_cnt);
    end
    out_ready = 1'b0;
    drive_one(IG_I_TYPE, 32'h0000_0005, 32'h0000_0013);
    drive_one(IG_I_TYPE, 32'h0000_0006, 32'h0000_0013);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_valid out_valid=%0b required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset valid=%0b inst=%08h cnt=%0d required 0/0/0",
               out_valid, out_inst, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready in_ready=%0b required 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || err_cnt !== '0) begin
        errors++;
        $display("FAIL stale_beat[%0d] valid=%0b cnt=%0d required 0/0", c, out_valid, err_cnt);
      end
    end
    $display("async reset: valid=%0b cnt=%0d", out_valid, err_cnt);
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_clr_cnt();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
